// File: rtl/filterbank_reorder_pkg.sv
// Shared definitions for the filterbank output reorder block: default
// geometry and the read-side FSM state encoding.
package filterbank_reorder_pkg;

   localparam int FB_N     = 8;   // filters per frame (power of 2)
   localparam int FB_LOGN  = 3;   // log2(FB_N)
   localparam int FB_WDTH  = 32;  // packed complex sample width
   localparam int FB_MWDTH = 1;   // side-band metadata width

   typedef enum logic {
      RD_IDLE = 1'b0,
      RD_READ = 1'b1
   } rd_state_e;

endpackage

// File: rtl/filterbank_reorder_if.sv
// Sample stream bundle: data, valid strobe, metadata and frame-start marker.
// The producer uses the master modport, the consumer the slave modport.
interface filterbank_reorder_if #(
   parameter int WDTH  = 32,
   parameter int MWDTH = 1
);
   logic [WDTH-1:0]  data;
   logic             nd;
   logic [MWDTH-1:0] m;
   logic             first;

   modport master (output data, output nd, output m, output first);
   modport slave  (input  data, input  nd, input  m, input  first);
endinterface

// File: rtl/filterbank_reorder_pingpong_ram.sv
// Simple dual-port RAM holding both ping-pong banks. Address is {bank,index}.
// The read port is registered and read-first, so a write and a read to the
// same word in one cycle returns the old contents.
module filterbank_reorder_pingpong_ram #(
   parameter int AW   = 4,
   parameter int WDTH = 32
) (
   input  logic            clk,
   input  logic            srst,
   input  logic            we,
   input  logic [AW-1:0]   waddr,
   input  logic [WDTH-1:0] wdata,
   input  logic            re,
   input  logic [AW-1:0]   raddr,
   output logic [WDTH-1:0] rdata
);

   logic [WDTH-1:0] mem [2**AW];
   logic [WDTH-1:0] rdata_q;

   // Write port: plain array store so the tools map it to block RAM.
   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   // Registered read port; cleared by reset so the output word starts at zero.
   always_ff @(posedge clk) begin
      if (srst) begin
         rdata_q <= '0;
      end else if (re) begin
         rdata_q <= mem[raddr];
      end
   end

   assign rdata = rdata_q;

endmodule

// File: rtl/filterbank_reorder.sv
// Collects N-sample filterbank frames into a ping-pong buffer and re-emits
// each frame in reversed filter order (N-1 down to 0). Frame alignment is
// checked against the first marker; any protocol violation sets a sticky error.
module filterbank_reorder
   import filterbank_reorder_pkg::*;
#(
   parameter int N     = FB_N,
   parameter int LOGN  = FB_LOGN,
   parameter int WDTH  = FB_WDTH,
   parameter int MWDTH = FB_MWDTH
) (
   input  logic                 clk,
   input  logic                 rst_n,   // active-high synchronous reset
   filterbank_reorder_if.slave  in_if,
   filterbank_reorder_if.master out_if,
   output logic                 error
);

   localparam logic [LOGN-1:0] LAST_IDX = LOGN'(N - 1);

   // write side
   logic [LOGN-1:0]  wcnt_q, wcnt_d;
   logic             wbank_q, wbank_d;
   logic             drop_q, drop_d;
   logic [1:0]       full_q, full_d;
   logic [MWDTH-1:0] meta_q [2];
   logic [MWDTH-1:0] meta_d [2];
   logic             error_q, error_d;
   logic             wr_en;
   logic [LOGN-1:0]  wr_idx;
   logic             wr_done;
   logic             wbank_busy;

   // read side
   rd_state_e        state_q, state_d;
   logic             rbank_q, rbank_d;
   logic [LOGN-1:0]  rcnt_q, rcnt_d;
   logic             rd_issue;
   logic             rd_last;

   // output registers
   logic             out_nd_q, out_nd_d;
   logic             out_first_q, out_first_d;
   logic [MWDTH-1:0] out_m_q, out_m_d;
   logic [WDTH-1:0]  ram_rdata;

   // A frame completes when the last filter index is stored; the reader
   // finishes a bank when it issues index 0 (rcnt at its last value).
   assign wr_done    = in_if.nd && !in_if.first && !drop_q && (wcnt_q == LAST_IDX);
   assign rd_last    = (state_q == RD_READ) && (rcnt_q == LAST_IDX);
   // A bank being released this very cycle counts as free for a new frame.
   assign wbank_busy = full_q[wbank_q] && !(rd_last && (rbank_q == wbank_q));

   // Writer: frame alignment, bank filling, overflow dropping, error flag.
   always_comb begin
      wcnt_d  = wcnt_q;
      wbank_d = wbank_q;
      drop_d  = drop_q;
      full_d  = full_q;
      meta_d  = meta_q;
      error_d = error_q;
      wr_en   = 1'b0;
      wr_idx  = wcnt_q;
      if (rd_last) begin
         full_d[rbank_q] = 1'b0;
      end
      if (in_if.nd) begin
         if (in_if.first) begin
            if (wcnt_q != '0) begin
               error_d = 1'b1;   // partial frame abandoned
            end
            if (wbank_busy) begin
               error_d = 1'b1;   // overflow: discard the whole new frame
               drop_d  = 1'b1;
               wcnt_d  = '0;
            end else begin
               wr_en           = 1'b1;
               wr_idx          = '0;
               meta_d[wbank_q] = in_if.m;
               wcnt_d          = LOGN'(1);
               drop_d          = 1'b0;
            end
         end else if (!drop_q) begin
            if (wcnt_q == '0) begin
               error_d = 1'b1;   // sample without a frame start
            end else begin
               wr_en = 1'b1;
               if (wr_done) begin
                  full_d[wbank_q] = 1'b1;
                  wbank_d         = ~wbank_q;
                  wcnt_d          = '0;
               end else begin
                  wcnt_d = wcnt_q + LOGN'(1);
               end
            end
         end
      end
   end

   // Writer state registers.
   always_ff @(posedge clk) begin
      if (rst_n) begin
         wcnt_q    <= '0;
         wbank_q   <= 1'b0;
         drop_q    <= 1'b0;
         full_q    <= '0;
         meta_q[0] <= '0;
         meta_q[1] <= '0;
         error_q   <= 1'b0;
      end else begin
         wcnt_q  <= wcnt_d;
         wbank_q <= wbank_d;
         drop_q  <= drop_d;
         full_q  <= full_d;
         meta_q  <= meta_d;
         error_q <= error_d;
      end
   end

   // Reader FSM: walk a full bank from index N-1 down to 0, chaining straight
   // into the other bank when it is (or is just becoming) full.
   always_comb begin
      state_d  = state_q;
      rbank_d  = rbank_q;
      rcnt_d   = rcnt_q;
      rd_issue = 1'b0;
      case (state_q)
         RD_IDLE: begin
            if (wr_done) begin
               state_d = RD_READ;
               rbank_d = wbank_q;
               rcnt_d  = '0;
            end
         end
         RD_READ: begin
            rd_issue = 1'b1;
            rcnt_d   = rcnt_q + LOGN'(1);
            if (rd_last) begin
               rcnt_d = '0;
               if (full_q[~rbank_q] || (wr_done && (wbank_q != rbank_q))) begin
                  rbank_d = ~rbank_q;
               end else begin
                  state_d = RD_IDLE;
               end
            end
         end
         default: state_d = RD_IDLE;
      endcase
   end

   // Reader FSM state register.
   always_ff @(posedge clk) begin
      if (rst_n) begin
         state_q <= RD_IDLE;
         rbank_q <= 1'b0;
         rcnt_q  <= '0;
      end else begin
         state_q <= state_d;
         rbank_q <= rbank_d;
         rcnt_q  <= rcnt_d;
      end
   end

   // Output strobes line up with the registered RAM read (one cycle behind issue).
   always_comb begin
      out_nd_d    = rd_issue;
      out_first_d = rd_issue && (rcnt_q == '0);
      out_m_d     = out_m_q;
      if (rd_issue) begin
         out_m_d = meta_q[rbank_q];
      end
   end

   // Output registers.
   always_ff @(posedge clk) begin
      if (rst_n) begin
         out_nd_q    <= 1'b0;
         out_first_q <= 1'b0;
         out_m_q     <= '0;
      end else begin
         out_nd_q    <= out_nd_d;
         out_first_q <= out_first_d;
         out_m_q     <= out_m_d;
      end
   end

   filterbank_reorder_pingpong_ram #(
      .AW   (LOGN + 1),
      .WDTH (WDTH)
   ) u_ram (
      .clk   (clk),
      .srst  (rst_n),
      .we    (wr_en),
      .waddr ({wbank_q, wr_idx}),
      .wdata (in_if.data),
      .re    (rd_issue),
      .raddr ({rbank_q, LAST_IDX - rcnt_q}),
      .rdata (ram_rdata)
   );

   assign out_if.data  = ram_rdata;
   assign out_if.nd    = out_nd_q;
   assign out_if.m     = out_m_q;
   assign out_if.first = out_first_q;
   assign error        = error_q;

endmodule
